// File: rtl/uart_initiator.sv
// uart_initiator: sends an NBYTES word MSB byte first over UART, then gathers
// NBYTES reply bytes into oData, with a per-byte reply timeout.
// Optional reply-vs-sent comparison: define UART_INITIATOR_CHECK_EN.
// uart_tx / uart_rx are 8N1 serialisers at CLK_FREQ/BAUD_RATE clocks per bit.

module uart_tx #(
    parameter int CLK_FREQ  = 125_000_000,
    parameter int BAUD_RATE = 115_200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] data,
    output logic       tx,
    output logic       busy,
    output logic       done
);
    localparam int DIV = CLK_FREQ / BAUD_RATE;
    localparam int CW  = $clog2(DIV) + 1;

    logic [9:0]    shift_q, shift_d;
    logic [CW-1:0] baud_q, baud_d;
    logic [3:0]    bits_q, bits_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;

    // Load start/data/stop on start, then shift one bit out per baud period
    always_comb begin
        shift_d = shift_q;
        baud_d  = baud_q;
        bits_d  = bits_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        if (!busy_q) begin
            if (start) begin
                shift_d = {1'b1, data, 1'b0};
                baud_d  = '0;
                bits_d  = 4'd10;
                busy_d  = 1'b1;
            end
        end else if (baud_q == CW'(DIV - 1)) begin
            baud_d  = '0;
            shift_d = {1'b1, shift_q[9:1]};
            bits_d  = bits_q - 4'd1;
            if (bits_q == 4'd1) begin
                busy_d = 1'b0;
                done_d = 1'b1;
            end
        end else begin
            baud_d = baud_q + CW'(1);
        end
    end

    // State registers; the shifter resets to all ones so the line idles high
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_q <= '1;
            baud_q  <= '0;
            bits_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            shift_q <= shift_d;
            baud_q  <= baud_d;
            bits_q  <= bits_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign tx   = shift_q[0];
    assign busy = busy_q;
    assign done = done_q;
endmodule

module uart_rx #(
    parameter int CLK_FREQ  = 125_000_000,
    parameter int BAUD_RATE = 115_200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] data,
    output logic       done
);
    localparam int DIV = CLK_FREQ / BAUD_RATE;
    localparam int CW  = $clog2(DIV) + 1;

    logic [1:0]    sync_q, sync_d;
    logic [CW-1:0] baud_q, baud_d;
    logic [3:0]    idx_q, idx_d;
    logic [7:0]    sh_q, sh_d;
    logic [7:0]    data_q, data_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          rx_s;

    assign rx_s = sync_q[1];

    // Synchronise rx, find a start edge, sample each bit near its centre
    always_comb begin
        sync_d = {sync_q[0], rx};
        baud_d = baud_q;
        idx_d  = idx_q;
        sh_d   = sh_q;
        data_d = data_q;
        busy_d = busy_q;
        done_d = 1'b0;
        if (!busy_q) begin
            if (!rx_s) begin
                busy_d = 1'b1;
                baud_d = CW'(DIV / 2);
                idx_d  = '0;
            end
        end else if (baud_q == CW'(DIV - 1)) begin
            baud_d = '0;
            idx_d  = idx_q + 4'd1;
            if (idx_q == 4'd0) begin
                if (rx_s) busy_d = 1'b0;          // glitch, not a real start bit
            end else if (idx_q == 4'd9) begin
                busy_d = 1'b0;
                if (rx_s) begin                   // good stop bit
                    done_d = 1'b1;
                    data_d = sh_q;
                end
            end else begin
                sh_d = {rx_s, sh_q[7:1]};
            end
        end else begin
            baud_d = baud_q + CW'(1);
        end
    end

    // State registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= 2'b11;
            baud_q <= '0;
            idx_q  <= '0;
            sh_q   <= '0;
            data_q <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            baud_q <= baud_d;
            idx_q  <= idx_d;
            sh_q   <= sh_d;
            data_q <= data_d;
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end

    assign data = data_q;
    assign done = done_q;
endmodule

module uart_initiator #(
    parameter int NBYTES         = 12,
    parameter int CLK_FREQ       = 125_000_000,
    parameter int BAUD_RATE      = 115_200,
    parameter int TIMEOUT_CYCLES = 125_000
) (
    input  logic                iClk,
    input  logic                iRstn,
    input  logic                iStart,
    input  logic [NBYTES*8-1:0] iData,
    input  logic                iRx,
    output logic                oTx,
    output logic [NBYTES*8-1:0] oData,
    output logic                oBusy,
    output logic                oDone,
    output logic                oTimeout,
    output logic                oMismatch
);
    localparam int W     = NBYTES * 8;
    localparam int CNT_W = $clog2(NBYTES) + 1;
    localparam int TMR_W = $clog2(TIMEOUT_CYCLES) + 1;

    typedef enum logic [2:0] {S_IDLE, S_TX, S_WAIT_TX, S_RX, S_DONE} state_t;

    state_t          state_q, state_d;
    logic [W-1:0]    tx_buf_q, tx_buf_d;
    logic [W-1:0]    rx_buf_q, rx_buf_d;
    logic [W-1:0]    data_q, data_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            timeout_q, timeout_d;
    logic            finish;
    logic            tx_start, tx_busy, tx_done, rx_done;
    logic [7:0]      rx_byte;
    logic            uart_rst;
`ifdef UART_INITIATOR_CHECK_EN
    logic [W-1:0]    ref_q, ref_d;
    logic            mismatch_q, mismatch_d;
`endif

    assign uart_rst = ~iRstn;

    uart_tx #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD_RATE)) u_tx (
        .clk(iClk), .rst(uart_rst), .start(tx_start), .data(tx_buf_q[W-1 -: 8]),
        .tx(oTx), .busy(tx_busy), .done(tx_done)
    );

    uart_rx #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD_RATE)) u_rx (
        .clk(iClk), .rst(uart_rst), .rx(iRx), .data(rx_byte), .done(rx_done)
    );

    // Transaction sequencing; results are registered on the way into DONE
    always_comb begin
        state_d   = state_q;
        tx_buf_d  = tx_buf_q;
        rx_buf_d  = rx_buf_q;
        data_d    = data_q;
        cnt_d     = cnt_q;
        timer_d   = timer_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        timeout_d = timeout_q;
        finish    = 1'b0;
        tx_start  = 1'b0;
`ifdef UART_INITIATOR_CHECK_EN
        ref_d      = ref_q;
        mismatch_d = mismatch_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (iStart) begin
                    tx_buf_d  = iData;
                    rx_buf_d  = '0;
                    cnt_d     = '0;
                    timeout_d = 1'b0;
                    busy_d    = 1'b1;
                    state_d   = S_TX;
`ifdef UART_INITIATOR_CHECK_EN
                    ref_d      = iData;
                    mismatch_d = 1'b0;
`endif
                end
            end
            S_TX: begin
                if ((cnt_q < CNT_W'(NBYTES)) && !tx_busy) begin
                    tx_start = 1'b1;
                    tx_buf_d = tx_buf_q << 8;
                    cnt_d    = cnt_q + CNT_W'(1);
                    state_d  = S_WAIT_TX;
                end
            end
            S_WAIT_TX: begin
                if (tx_done) begin
                    if (cnt_q == CNT_W'(NBYTES)) begin
                        cnt_d   = '0;
                        timer_d = '0;
                        state_d = S_RX;
                    end else begin
                        state_d = S_TX;
                    end
                end
            end
            S_RX: begin
                // A byte arriving on the expiry cycle takes priority over the timeout
                if (rx_done) begin
                    rx_buf_d = (rx_buf_q << 8) | W'(rx_byte);
                    cnt_d    = cnt_q + CNT_W'(1);
                    timer_d  = '0;
                    if (cnt_q == CNT_W'(NBYTES - 1)) finish = 1'b1;
                end else if (timer_q == TMR_W'(TIMEOUT_CYCLES - 1)) begin
                    timeout_d = 1'b1;
                    finish    = 1'b1;
                end else if (timer_q != {TMR_W{1'b1}}) begin
                    timer_d = timer_q + TMR_W'(1);
                end
                if (finish) begin
                    data_d  = rx_buf_d;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = S_DONE;
`ifdef UART_INITIATOR_CHECK_EN
                    mismatch_d = (rx_buf_d != ref_q) || timeout_d;
`endif
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // FSM and datapath registers
    always_ff @(posedge iClk or negedge iRstn) begin
        if (!iRstn) begin
            state_q   <= S_IDLE;
            tx_buf_q  <= '0;
            rx_buf_q  <= '0;
            data_q    <= '0;
            cnt_q     <= '0;
            timer_q   <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
`ifdef UART_INITIATOR_CHECK_EN
            ref_q      <= '0;
            mismatch_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            tx_buf_q  <= tx_buf_d;
            rx_buf_q  <= rx_buf_d;
            data_q    <= data_d;
            cnt_q     <= cnt_d;
            timer_q   <= timer_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            timeout_q <= timeout_d;
`ifdef UART_INITIATOR_CHECK_EN
            ref_q      <= ref_d;
            mismatch_q <= mismatch_d;
`endif
        end
    end

    assign oData    = data_q;
    assign oBusy    = busy_q;
    assign oDone    = done_q;
    assign oTimeout = timeout_q;
`ifdef UART_INITIATOR_CHECK_EN
    assign oMismatch = mismatch_q;
`else
    assign oMismatch = 1'b0;
`endif
endmodule

// File: doc/uart_initiator.md
Name: uart_initiator

Overview:
Host-side counterpart of the UART echo responder. On a start pulse it serialises an NBYTES parallel word over UART, most significant byte first, then collects NBYTES reply bytes into a parallel word. A per-byte timeout bounds the wait for the reply. It instantiates the existing uart_tx and uart_rx modules and is intended to drive the responder board, or a simulation model of it, from an FPGA-side test harness.

Parameters:
NBYTES, 12, bytes per transaction in each direction
CLK_FREQ, 125_000_000, clock frequency in Hz; passed to uart_tx and uart_rx
BAUD_RATE, 115_200, serial rate; passed to uart_tx and uart_rx
TIMEOUT_CYCLES, 125_000, maximum idle clock cycles allowed between reply bytes

Ports:
iClk  in  1  clock
iRstn  in  1  asynchronous active-low reset
iStart  in  1  single-cycle start request, sampled only in IDLE
iData  in  NBYTES*8  payload; latched on an accepted iStart
iRx  in  1  serial input from the responder
oTx  out  1  serial output to the responder
oData  out  NBYTES*8  reply word; first received byte ends up in the MSBs
oBusy  out  1  high from the cycle after an accepted iStart until DONE
oDone  out  1  one-cycle pulse at the end of a transaction
oTimeout  out  1  sticky flag: the last transaction ended by timeout
oMismatch  out  1  see Optional Feature; constant 0 when the feature is compiled out

Behaviour:
- Reset (iRstn=0, asynchronous): FSM=IDLE; all counters, buffers and tx byte cleared.
  - Output reset values: oData=0, oBusy=0, oDone=0, oTimeout=0, oMismatch=0, oTx=1 (idle line).
  - uart_tx and uart_rx reset inputs are driven by ~iRstn.
- States: IDLE, TX, WAIT_TX, RX, DONE.
- IDLE:
  - iStart=1 latches iData into the tx shift buffer and the reference copy.
  - Clears the rx buffer, byte counter, oTimeout and oMismatch.
  - Next state TX; oBusy=1 from that cycle.
- TX, entered when counter<NBYTES and uart_tx is not busy:
  - Assert uart_tx start for exactly one cycle with the tx buffer MSB byte.
  - Shift the tx buffer left by 8, increment the counter, go to WAIT_TX.
- WAIT_TX:
  - uart_tx start is held low.
  - On uart_tx done: if counter==NBYTES, clear counter and timer and go to RX; otherwise go to TX.
- Bytes arriving on uart_rx during TX or WAIT_TX are discarded.
- RX:
  - On uart_rx done: shift the rx buffer left by 8 with the new byte in the LSBs, increment the counter, clear the timer.
  - When counter reaches NBYTES: go to DONE.
  - With no byte: the timer increments. At TIMEOUT_CYCLES-1, set oTimeout=1 and go to DONE.
  - If byte arrival and timer expiry occur in the same cycle, the byte wins: it is stored and the timer is cleared.
- DONE:
  - oData <= rx buffer. On timeout this is a partial reply: received bytes right-aligned, zeros above.
  - oDone=1 for one cycle, oBusy=0, next state IDLE.
- iStart while oBusy=1 is ignored with no side effects. iStart in the same cycle as oDone is also ignored; it is accepted from the following IDLE cycle.
- Reset mid-transaction aborts immediately. The oTx idle line is restored within one cycle of reset assertion.
- Counter width is $clog2(NBYTES)+1 and never wraps. Timer width is $clog2(TIMEOUT_CYCLES)+1 and saturates.

Optional Feature:
- Macro: UART_INITIATOR_CHECK_EN.
- Defined:
  - In DONE, oMismatch <= (rx buffer != reference copy) OR timeout.
  - oMismatch is sticky until the next accepted iStart.
  - Adds an NBYTES*8 reference register and comparator.
- Undefined: no reference register; oMismatch tied to 0.

Test Plan:
- Echo model on iRx; iData=96'h48656C6C6F5F576F726C6421, iStart pulse. Required: 12 frames on oTx in MSB-first order ('H' first); then oDone pulse, oData=iData, oTimeout=0, oMismatch=0.
- iRx held at 1 after TX completes, TIMEOUT_CYCLES=1000. Required: oDone exactly 1000 cycles after the last tx done; oTimeout=1; oData=0.
- Responder replies with 5 bytes then stops. Required: oTimeout=1; oData low 40 bits hold the 5 bytes in order, upper bits zero. With the macro defined, oMismatch=1.
- iStart pulsed at byte 3 of TX. Required: ignored; the transaction completes unchanged with exactly 12 tx frames.
- iRstn low for 2 cycles during the byte-6 frame. Required: oTx=1, oBusy=0 and all outputs at reset values; a new iStart afterwards completes a normal echo.
- Macro defined, echo model flips bit 0 of byte 7. Required: oDone pulse, oMismatch=1, oTimeout=0; a following clean transaction clears oMismatch to 0.
